// File: rtl/c17_bist_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_driver_if
//  Description : Stimulus/observation bundle between the c17 BIST driver and
//                the balanced c17 netlist plus its run-control/status signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface c17_bist_driver_if #(
    parameter int ERR_W = 16
);
    logic             start;
    logic [4:0]       dut_in;
    logic [1:0]       dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      first_fail_idx;

    // BIST driver side
    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail_idx
    );

    // Harness / netlist side
    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail_idx
    );
endinterface
`default_nettype wire

// File: rtl/c17_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module      : c17_bist_driver
//  Description : BIST driver and response checker for the path-balanced c17
//                netlist. Issues LFSR vectors, delays the golden response by
//                the netlist depth and scores the returned outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module c17_bist_driver #(
    parameter int          LATENCY      = 5,
    parameter int          NUM_PATTERNS = 256,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          ERR_W        = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    c17_bist_driver_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_IDX   = 16'(NUM_PATTERNS - 1);
    localparam logic [5:0]  DRAIN_LAST = 6'(LATENCY - 1);
    localparam int          DL_W       = 19;   // {valid, expected[1:0], idx[15:0]}

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward the LSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Golden c17: a[0..4] = N1,N2,N3,N6,N7; result = {N23, N22}
    function automatic logic [1:0] c17_golden(input logic [4:0] a);
        logic w_n3n6;
        logic w_n22;
        logic w_n23;
        w_n3n6 = a[2] & a[3];
        w_n22  = (a[0] & a[2]) | (a[1] & ~w_n3n6);
        w_n23  = ~w_n3n6 & (a[1] | a[4]);
        return {w_n23, w_n22};
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [4:0]         dut_in_q, dut_in_d;
    logic [15:0]        issue_idx_q, issue_idx_d;
    logic [5:0]         drain_cnt_q, drain_cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [15:0]        ffi_q, ffi_d;
    logic [DL_W-1:0]    dl_q [LATENCY];
    logic [DL_W-1:0]    w_dl_push;

    logic               w_head_valid;
    logic [1:0]         w_head_exp;
    logic [15:0]        w_head_idx;

    // The vector currently on dut_in enters the delay line alongside its
    // expected response; it reaches the head exactly LATENCY cycles later.
    assign w_dl_push    = {(state_q == S_RUN), c17_golden(dut_in_q), issue_idx_q};
    assign w_head_valid = dl_q[LATENCY-1][18];
    assign w_head_exp   = dl_q[LATENCY-1][17:16];
    assign w_head_idx   = dl_q[LATENCY-1][15:0];

    // State register and run datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED_EFF;
            dut_in_q    <= 5'd0;
            issue_idx_q <= 16'd0;
            drain_cnt_q <= 6'd0;
            err_q       <= '0;
            ffi_q       <= 16'hFFFF;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            dut_in_q    <= dut_in_d;
            issue_idx_q <= issue_idx_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            ffi_q       <= ffi_d;
        end
    end

    // Delay line of expected responses, one registered stage per cycle of depth
    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dl
            if (gi == 0) begin : g_first
                // First stage captures the vector being driven this cycle
                always_ff @(posedge clk) begin
                    if (rst) dl_q[0] <= '0;
                    else     dl_q[0] <= w_dl_push;
                end
            end else begin : g_rest
                // Later stages simply shift
                always_ff @(posedge clk) begin
                    if (rst) dl_q[gi] <= '0;
                    else     dl_q[gi] <= dl_q[gi-1];
                end
            end
        end
    endgenerate

    // Next-state, stimulus generation and response scoring
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        dut_in_d    = 5'd0;
        issue_idx_d = issue_idx_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        ffi_d       = ffi_q;

        // Scoring comes first so that a restart below wins over it; the head
        // is never valid in IDLE/DONE, so nothing is lost.
        if (w_head_valid && (bus.dut_out != w_head_exp)) begin
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + ERR_W'(1);
            end
            if (ffi_q == 16'hFFFF) begin
                ffi_d = w_head_idx;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    // Vector 0 is the seed itself, presented on the first RUN cycle
                    state_d     = S_RUN;
                    dut_in_d    = SEED_EFF[4:0];
                    lfsr_d      = lfsr_step(SEED_EFF);
                    issue_idx_d = 16'd0;
                    err_d       = '0;
                    ffi_d       = 16'hFFFF;
                end
            end
            S_RUN: begin
                if (issue_idx_q == LAST_IDX) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 6'd0;
                end else begin
                    dut_in_d    = lfsr_q[4:0];
                    lfsr_d      = lfsr_step(lfsr_q);
                    issue_idx_d = issue_idx_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = (state_q == S_DONE) && (err_q == '0);
    assign bus.err_count      = err_q;
    assign bus.first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_c17_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c17_bist_driver
//  Description : Directed self-checking bench for c17_bist_driver with three
//                parameterisations and behavioural netlist models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c17_bist_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    c17_bist_driver_if              if_a ();
    c17_bist_driver_if              if_b ();
    c17_bist_driver_if #(.ERR_W(4)) if_c ();

    c17_bist_driver u_a (.clk(clk), .rst(rst), .bus(if_a));
    c17_bist_driver #(.SEED(16'h001F), .NUM_PATTERNS(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    c17_bist_driver #(.ERR_W(4), .NUM_PATTERNS(20))      u_c (.clk(clk), .rst(rst), .bus(if_c));

    // c17 as its NAND-gate netlist: returns {N23, N22}
    function automatic logic [1:0] c17_nand(input logic [4:0] a);
        logic n10, n11, n16, n19;
        n10 = ~(a[0] & a[2]);
        n11 = ~(a[2] & a[3]);
        n16 = ~(a[1] & n11);
        n19 = ~(n11 & a[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    // Netlist models: register pipes on dut_in followed by c17
    logic [4:0] pipe_a [5];
    logic [4:0] pipe_b [5];
    logic [4:0] pipe_c [5];
    int         delay_a = 5;

    always_ff @(posedge clk) begin
        pipe_a[0] <= if_a.dut_in;
        pipe_b[0] <= if_b.dut_in;
        pipe_c[0] <= if_c.dut_in;
        for (int i = 1; i < 5; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
            pipe_c[i] <= pipe_c[i-1];
        end
    end

    assign if_a.dut_out = (delay_a == 4) ? c17_nand(pipe_a[3]) : c17_nand(pipe_a[4]);
    assign if_b.dut_out = c17_nand(pipe_b[4]) & 2'b10;     // N22 stuck-at-0
    assign if_c.dut_out = ~c17_nand(pipe_c[4]);            // inverted outputs

    // Expected vector stream for the default seed
    logic [4:0] v [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run on instance A and follows it to done
    task automatic run_a(input bit hold, output int done_cyc, output int seq_err,
                         output logic [15:0] err_first);
        if_a.start = 1'b1;
        done_cyc   = 0;
        seq_err    = 0;
        err_first  = 16'h0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (!hold) if_a.start = 1'b0;
            if (k == 1) err_first = if_a.err_count;
            if (k <= 256) begin
                if (if_a.dut_in !== v[k-1]) seq_err++;
            end else if (if_a.dut_in !== 5'd0) begin
                seq_err++;
            end
            if (if_a.done === 1'b1) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] s;
        int          exp_cnt;
        logic [15:0] exp_first;
        logic [1:0]  seen;
        int          dc, se, cyc;
        logic [15:0] e1;

        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;

        s = 16'hACE1;
        for (int k = 0; k < 256; k++) begin
            v[k] = s[4:0];
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end

        // With a 4-deep netlist, pattern k is scored against pattern k+1
        exp_cnt   = 0;
        exp_first = 16'hFFFF;
        for (int k = 0; k < 256; k++) begin
            seen = (k < 255) ? c17_nand(v[k+1]) : c17_nand(5'd0);
            if (seen != c17_nand(v[k])) begin
                exp_cnt++;
                if (exp_first == 16'hFFFF) exp_first = 16'(k);
            end
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dut_in", 32'(if_a.dut_in), 32'h0);
        check("rst_busy",   32'(if_a.busy), 32'h0);
        check("rst_done",   32'(if_a.done), 32'h0);
        check("rst_pass",   32'(if_a.pass), 32'h0);
        check("rst_err",    32'(if_a.err_count), 32'h0);
        check("rst_ffi",    32'(if_a.first_fail_idx), 32'hFFFF);
        check("rst_err_c",  32'(if_c.err_count), 32'h0);

        // Fault-free run with defaults
        run_a(1'b0, dc, se, e1);
        check("clean_done_cyc", 32'(dc), 32'd262);
        check("clean_seq",      32'(se), 32'd0);
        check("clean_pass",     32'(if_a.pass), 32'h1);
        check("clean_err",      32'(if_a.err_count), 32'h0);
        check("clean_ffi",      32'(if_a.first_fail_idx), 32'hFFFF);
        check("clean_busy",     32'(if_a.busy), 32'h0);

        // Netlist one cycle shorter than LATENCY
        delay_a = 4;
        run_a(1'b0, dc, se, e1);
        check("short_done_cyc", 32'(dc), 32'd262);
        check("short_err",      32'(if_a.err_count), 32'(exp_cnt));
        check("short_ffi",      32'(if_a.first_fail_idx), 32'(exp_first));
        check("short_err_nz",   32'(if_a.err_count != 16'h0), 32'h1);
        check("short_pass",     32'(if_a.pass), 32'h0);

        // Reset mid-run at issue_idx 10, then a clean rerun
        delay_a = 5;
        if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_dut_in", 32'(if_a.dut_in), 32'(v[10]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_dut_in", 32'(if_a.dut_in), 32'h0);
        check("mid_rst_busy",   32'(if_a.busy), 32'h0);
        check("mid_rst_done",   32'(if_a.done), 32'h0);
        check("mid_rst_err",    32'(if_a.err_count), 32'h0);
        check("mid_rst_ffi",    32'(if_a.first_fail_idx), 32'hFFFF);
        run_a(1'b0, dc, se, e1);
        check("rerun_done_cyc", 32'(dc), 32'd262);
        check("rerun_seq",      32'(se), 32'd0);
        check("rerun_err",      32'(if_a.err_count), 32'h0);
        check("rerun_pass",     32'(if_a.pass), 32'h1);

        // start held high through RUN/DRAIN, then a restart from DONE
        delay_a = 4;
        run_a(1'b1, dc, se, e1);
        check("hold_done_cyc", 32'(dc), 32'd262);
        check("hold_seq",      32'(se), 32'd0);
        check("hold_err",      32'(if_a.err_count), 32'(exp_cnt));
        delay_a = 5;
        run_a(1'b0, dc, se, e1);
        check("restart_err_cleared", 32'(e1), 32'h0);
        check("restart_done_cyc",    32'(dc), 32'd262);
        check("restart_seq",         32'(se), 32'd0);
        check("restart_pass",        32'(if_a.pass), 32'h1);

        // Single pattern 5'b11111 against N22 stuck-at-0
        if_b.start = 1'b1;
        @(posedge clk); #1;
        if_b.start = 1'b0;
        check("sa0_dut_in", 32'(if_b.dut_in), 32'h1F);
        check("sa0_busy",   32'(if_b.busy), 32'h1);
        cyc = 0;
        for (int k = 2; k <= 50; k++) begin
            @(posedge clk); #1;
            if (if_b.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        check("sa0_done_cyc", 32'(cyc), 32'd7);
        check("sa0_err",      32'(if_b.err_count), 32'h1);
        check("sa0_ffi",      32'(if_b.first_fail_idx), 32'h0);
        check("sa0_pass",     32'(if_b.pass), 32'h0);

        // Inverted netlist, 4-bit counter saturates
        if_c.start = 1'b1;
        @(posedge clk); #1;
        if_c.start = 1'b0;
        cyc = 0;
        for (int k = 2; k <= 80; k++) begin
            @(posedge clk); #1;
            if (if_c.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        check("sat_done_cyc", 32'(cyc), 32'd26);
        check("sat_err",      32'(if_c.err_count), 32'hF);
        check("sat_ffi",      32'(if_c.first_fail_idx), 32'h0);
        check("sat_pass",     32'(if_c.pass), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
